// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR / trap unit.
// Holds CSR addresses, csr_op encodings, interrupt cause codes, WARL masks
// and the read-modify-write helpers used by the CSR datapath.
package csr_trap_unit_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic [1:0] {
        CSR_OP_RO = 2'b00,
        CSR_OP_RW = 2'b01,
        CSR_OP_RS = 2'b10,
        CSR_OP_RC = 2'b11
    } csr_op_e;

    // Interrupt cause codes
    localparam logic [31:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;

    // WARL masks / fixed fields
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;  // MPIE(7), MIE(3)
    localparam logic [31:0] MSTATUS_FIXED = 32'h0000_1800;  // MPP reads 2'b11
    localparam logic [31:0] MIE_WMASK     = 32'h0000_0880;  // MEIE(11), MTIE(7)
    localparam logic [31:0] MTVEC_MASK    = 32'hFFFF_FFFD;  // bit1 reads 0
    localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;  // bits 1:0 read 0

    // New CSR value for a read-modify-write operation
    function automatic logic [31:0] csr_apply_op(input logic [1:0] op,
                                                 input logic [31:0] old_value,
                                                 input logic [31:0] operand);
        logic [31:0] result;
        case (op)
            CSR_OP_RW: result = operand;
            CSR_OP_RS: result = old_value | operand;
            CSR_OP_RC: result = old_value & ~operand;
            default:   result = old_value;
        endcase
        return result;
    endfunction

    // Set/clear with a zero operand is a pure read and never counts as a write
    function automatic logic csr_op_writes(input logic [1:0] op,
                                           input logic [31:0] operand);
        logic result;
        case (op)
            CSR_OP_RW: result = 1'b1;
            CSR_OP_RS: result = (operand != 32'h0000_0000);
            CSR_OP_RC: result = (operand != 32'h0000_0000);
            default:   result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between the pipeline (master) and the CSR unit (slave).
//   csr_en/csr_op/csr_addr/csr_wdata : request from the pipeline
//   csr_rdata/csr_illegal            : combinational response from the CSR unit
interface csr_trap_unit_if #(parameter int XLEN = 32);
    logic            csr_en;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (output csr_en, csr_op, csr_addr, csr_wdata,
                    input  csr_rdata, csr_illegal);
    modport slave  (input  csr_en, csr_op, csr_addr, csr_wdata,
                    output csr_rdata, csr_illegal);
endinterface

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with increment enable and per-half write.
//   clock/reset : rising-edge clock, async active-high reset
//   inc         : add one this cycle (carry ripples into the high word)
//   wr_lo/wr_hi : load wdata into that half; the other half holds this cycle
//   value       : current count
module csr_counter64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);
    logic [63:0] count_r;
    logic [63:0] count_next_s;

    // Next count: a write to either half replaces that cycle's increment
    always_comb begin
        count_next_s = count_r;
        if (wr_lo) begin
            count_next_s = {count_r[63:32], wdata};
        end else if (wr_hi) begin
            count_next_s = {wdata, count_r[31:0]};
        end else begin
            count_next_s = count_r + {63'd0, inc};
        end
    end

    // Count register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 64'd0;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign value = count_r;
endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with trap entry/return, interrupt request and counters.
//   clock/reset        : rising-edge clock, async active-high reset
//   bus (slave)        : CSR read/modify/write access, combinational rdata/illegal
//   exc_valid/cause/pc/tval : trap commit; mret : trap return commit
//   instret            : instruction retired (minstret increment)
//   irq_timer/irq_ext  : level interrupt lines (visible in mip)
//   irq_req/irq_cause  : enabled pending interrupt and its cause
//   trap_vector        : handler PC for exc_cause; mepc_out : current mepc
module csr_trap_unit
    import csr_trap_unit_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter bit          HAS_COUNTERS = 1'b1,
    parameter logic [31:0] HART_ID      = 32'h0000_0000
) (
    input  logic            clock,
    input  logic            reset,
    csr_trap_unit_if.slave  bus,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    input  logic            instret,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] trap_vector,
    output logic [XLEN-1:0] mepc_out
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("csr_trap_unit supports XLEN=32 only");
    end

    logic        mie_bit_r, mpie_bit_r, mtie_r, meie_r;
    logic [31:0] mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [31:0] mstatus_s, mie_csr_s, mip_s, old_s, new_s, vec_off_s;
    logic [63:0] mcycle_s, minstret_s;
    logic        impl_s, ro_s, writes_s, illegal_s, csr_wr_s;
    logic        wr_cyc_lo_s, wr_cyc_hi_s, wr_ret_lo_s, wr_ret_hi_s;

    assign mstatus_s = MSTATUS_FIXED | {24'd0, mpie_bit_r, 3'd0, mie_bit_r, 3'd0};
    assign mie_csr_s = {20'd0, meie_r, 3'd0, mtie_r, 7'd0};
    assign mip_s     = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};

    // Address decode and read mux
    always_comb begin
        impl_s = 1'b1;
        ro_s   = 1'b0;
        old_s  = 32'h0000_0000;
        case (bus.csr_addr)
            CSR_MSTATUS:   old_s = mstatus_s;
            CSR_MIE:       old_s = mie_csr_s;
            CSR_MTVEC:     old_s = mtvec_r;
            CSR_MSCRATCH:  old_s = mscratch_r;
            CSR_MEPC:      old_s = mepc_r;
            CSR_MCAUSE:    old_s = mcause_r;
            CSR_MTVAL:     old_s = mtval_r;
            CSR_MIP:       begin old_s = mip_s;   ro_s = 1'b1; end
            CSR_MHARTID:   begin old_s = HART_ID; ro_s = 1'b1; end
            CSR_MCYCLE:    begin old_s = mcycle_s[31:0];    impl_s = HAS_COUNTERS; end
            CSR_MCYCLEH:   begin old_s = mcycle_s[63:32];   impl_s = HAS_COUNTERS; end
            CSR_MINSTRET:  begin old_s = minstret_s[31:0];  impl_s = HAS_COUNTERS; end
            CSR_MINSTRETH: begin old_s = minstret_s[63:32]; impl_s = HAS_COUNTERS; end
            default:       impl_s = 1'b0;
        endcase
    end

    assign writes_s  = csr_op_writes(bus.csr_op, bus.csr_wdata);
    assign illegal_s = bus.csr_en & (~impl_s | (ro_s & writes_s));
    assign new_s     = csr_apply_op(bus.csr_op, old_s, bus.csr_wdata);
    // Trap entry and mret each suppress a same-cycle CSR write completely
    assign csr_wr_s  = bus.csr_en & ~illegal_s & writes_s & ~exc_valid & ~mret;

    assign bus.csr_illegal = illegal_s;
    assign bus.csr_rdata   = illegal_s ? 32'h0000_0000 : old_s;

    assign wr_cyc_lo_s = csr_wr_s & (bus.csr_addr == CSR_MCYCLE);
    assign wr_cyc_hi_s = csr_wr_s & (bus.csr_addr == CSR_MCYCLEH);
    assign wr_ret_lo_s = csr_wr_s & (bus.csr_addr == CSR_MINSTRET);
    assign wr_ret_hi_s = csr_wr_s & (bus.csr_addr == CSR_MINSTRETH);

    // Status, trap and scratch registers: trap entry > mret > CSR write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mie_bit_r  <= 1'b0;
            mpie_bit_r <= 1'b0;
            mtie_r     <= 1'b0;
            meie_r     <= 1'b0;
            mtvec_r    <= MTVEC_RESET & MTVEC_MASK;
            mscratch_r <= 32'h0000_0000;
            mepc_r     <= 32'h0000_0000;
            mcause_r   <= 32'h0000_0000;
            mtval_r    <= 32'h0000_0000;
        end else if (exc_valid) begin
            mepc_r     <= exc_pc & MEPC_MASK;
            mcause_r   <= exc_cause;
            mtval_r    <= exc_tval;
            mpie_bit_r <= mie_bit_r;
            mie_bit_r  <= 1'b0;
        end else if (mret) begin
            mie_bit_r  <= mpie_bit_r;
            mpie_bit_r <= 1'b1;
        end else if (csr_wr_s) begin
            case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mie_bit_r  <= new_s[3];
                    mpie_bit_r <= new_s[7];
                end
                CSR_MIE: begin
                    mtie_r <= new_s[7];
                    meie_r <= new_s[11];
                end
                CSR_MTVEC:    mtvec_r    <= new_s & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_r <= new_s;
                CSR_MEPC:     mepc_r     <= new_s & MEPC_MASK;
                CSR_MCAUSE:   mcause_r   <= new_s;
                CSR_MTVAL:    mtval_r    <= new_s;
                default:      mscratch_r <= mscratch_r;
            endcase
        end else begin
            mscratch_r <= mscratch_r;
        end
    end

    if (HAS_COUNTERS) begin : g_counters
        csr_counter64 u_mcycle (
            .clock (clock), .reset (reset), .inc (1'b1),
            .wr_lo (wr_cyc_lo_s), .wr_hi (wr_cyc_hi_s),
            .wdata (new_s), .value (mcycle_s)
        );
        csr_counter64 u_minstret (
            .clock (clock), .reset (reset), .inc (instret),
            .wr_lo (wr_ret_lo_s), .wr_hi (wr_ret_hi_s),
            .wdata (new_s), .value (minstret_s)
        );
    end else begin : g_no_counters
        assign mcycle_s   = 64'd0;
        assign minstret_s = 64'd0;
    end

    // Interrupt request: external wins over timer
    always_comb begin
        irq_req   = 1'b0;
        irq_cause = 32'h0000_0000;
        if (mie_bit_r & meie_r & irq_ext) begin
            irq_req   = 1'b1;
            irq_cause = CAUSE_M_EXT_IRQ;
        end else if (mie_bit_r & mtie_r & irq_timer) begin
            irq_req   = 1'b1;
            irq_cause = CAUSE_M_TIMER_IRQ;
        end else begin
            irq_req   = 1'b0;
            irq_cause = 32'h0000_0000;
        end
    end

    // Vectored mode offsets only interrupts, by 4 * cause code
    assign vec_off_s   = {1'b0, exc_cause[30:0]} << 2;
    assign trap_vector = (mtvec_r[0] & exc_cause[31]) ?
                         ({mtvec_r[31:2], 2'b00} + vec_off_s) : {mtvec_r[31:2], 2'b00};
    assign mepc_out    = mepc_r;
endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed steps followed by random traffic,
// every cycle compared against a behavioural CSR model.
module tb_csr_trap_unit;
    localparam logic [31:0] HART = 32'h0000_0005;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        exc_valid = 1'b0, mret = 1'b0, instret = 1'b0;
    logic        irq_timer = 1'b0, irq_ext = 1'b0;
    logic [31:0] exc_cause = 32'd0, exc_pc = 32'd0, exc_tval = 32'd0;
    logic        irq_req;
    logic [31:0] irq_cause, trap_vector, mepc_out;
    int          errors = 0;
    int          checks = 0;

    csr_trap_unit_if #(.XLEN(32)) bus ();

    csr_trap_unit #(.XLEN(32), .MTVEC_RESET(32'h0000_0000), .HAS_COUNTERS(1'b1), .HART_ID(HART)) dut (
        .clock (clock), .reset (reset), .bus (bus),
        .exc_valid (exc_valid), .exc_cause (exc_cause), .exc_pc (exc_pc), .exc_tval (exc_tval),
        .mret (mret), .instret (instret), .irq_timer (irq_timer), .irq_ext (irq_ext),
        .irq_req (irq_req), .irq_cause (irq_cause), .trap_vector (trap_vector), .mepc_out (mepc_out)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_mcycle, m_minstret;

    task automatic model_reset();
        m_mstatus = 32'h0000_1800; m_mie = 32'd0; m_mtvec = 32'd0; m_mscratch = 32'd0;
        m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0; m_mcycle = 64'd0; m_minstret = 64'd0;
    endtask

    function automatic void model_read(input logic [11:0] a, output bit impl, output bit ro,
                                       output logic [31:0] v);
        impl = 1'b1; ro = 1'b0; v = 32'd0;
        case (a)
            12'h300: v = m_mstatus;
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: begin ro = 1'b1; v = (irq_timer ? 32'h80 : 32'h0) | (irq_ext ? 32'h800 : 32'h0); end
            12'hF14: begin ro = 1'b1; v = HART; end
            12'hB00: v = m_mcycle[31:0];
            12'hB80: v = m_mcycle[63:32];
            12'hB02: v = m_minstret[31:0];
            12'hB82: v = m_minstret[63:32];
            default: impl = 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare combinational outputs with the model, then advance the model
    task automatic tick();
        bit impl, ro, wr, ill, wc, wi;
        logic [31:0] old, nv, ecause, tv;
        #1;
        model_read(bus.csr_addr, impl, ro, old);
        wr  = (bus.csr_op == 2'b01) || (bus.csr_op != 2'b00 && bus.csr_wdata != 32'd0);
        ill = !impl || (ro && wr);
        if (bus.csr_en) begin
            check("csr_illegal", {31'd0, bus.csr_illegal}, {31'd0, ill});
            check("csr_rdata", bus.csr_rdata, ill ? 32'd0 : old);
        end
        if (m_mstatus[3] && m_mie[11] && irq_ext)       ecause = 32'h8000_000B;
        else if (m_mstatus[3] && m_mie[7] && irq_timer) ecause = 32'h8000_0007;
        else                                            ecause = 32'd0;
        check("irq_req", {31'd0, irq_req}, {31'd0, ecause != 32'd0});
        check("irq_cause", irq_cause, ecause);
        tv = m_mtvec & 32'hFFFF_FFFC;
        if (m_mtvec[0] && exc_cause[31]) tv = tv + (exc_cause & 32'h7FFF_FFFF) * 32'd4;
        check("trap_vector", trap_vector, tv);
        check("mepc_out", mepc_out, m_mepc);
        @(posedge clock);
        case (bus.csr_op)
            2'b01:   nv = bus.csr_wdata;
            2'b10:   nv = old | bus.csr_wdata;
            2'b11:   nv = old & ~bus.csr_wdata;
            default: nv = old;
        endcase
        wc = 1'b0; wi = 1'b0;
        if (exc_valid) begin
            m_mepc = exc_pc & 32'hFFFF_FFFC; m_mcause = exc_cause; m_mtval = exc_tval;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
        end else if (mret) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (bus.csr_en && !ill && wr) begin
            case (bus.csr_addr)
                12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
                12'h304: m_mie      = nv & 32'h880;
                12'h305: m_mtvec    = nv & ~32'h2;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc     = nv & ~32'h3;
                12'h342: m_mcause   = nv;
                12'h343: m_mtval    = nv;
                12'hB00: begin m_mcycle[31:0]    = nv; wc = 1'b1; end
                12'hB80: begin m_mcycle[63:32]   = nv; wc = 1'b1; end
                12'hB02: begin m_minstret[31:0]  = nv; wi = 1'b1; end
                12'hB82: begin m_minstret[63:32] = nv; wi = 1'b1; end
                default: ;
            endcase
        end
        if (!wc) m_mcycle = m_mcycle + 64'd1;
        if (!wi && instret) m_minstret = m_minstret + 64'd1;
        @(negedge clock);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_en = 1'b1; bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = d;
        tick();
        bus.csr_en = 1'b0;
    endtask

    task automatic rd_expect(input logic [11:0] a, input logic [31:0] e, input string tag);
        bus.csr_en = 1'b1; bus.csr_op = 2'b00; bus.csr_addr = a; bus.csr_wdata = 32'd0;
        #1 check(tag, bus.csr_rdata, e);
        tick();
        bus.csr_en = 1'b0;
    endtask

    // Assert reset (possibly in the middle of a committing trap) and release it
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("reset_irq_req", {31'd0, irq_req}, 32'd0);
        check("reset_mepc", mepc_out, 32'd0);
        @(posedge clock);
        @(negedge clock);
        exc_valid = 1'b0; mret = 1'b0; instret = 1'b0;
        bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
        reset = 1'b0;
    endtask

    logic [11:0] alist [15] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h301};

    initial begin
        bus.csr_en = 1'b0; bus.csr_op = 2'b00; bus.csr_addr = 12'h000; bus.csr_wdata = 32'd0;
        irq_timer = 1'b1; irq_ext = 1'b1;
        do_reset();
        irq_timer = 1'b0; irq_ext = 1'b0;

        // Reset values, hart id, unimplemented address
        rd_expect(12'h300, 32'h0000_1800, "mstatus_reset");
        rd_expect(12'hF14, HART, "mhartid");
        bus.csr_en = 1'b1; bus.csr_op = 2'b00; bus.csr_addr = 12'h7C0;
        #1 check("illegal_7c0", {31'd0, bus.csr_illegal}, 32'd1);
        check("rdata_7c0", bus.csr_rdata, 32'd0);
        tick();

        // Interrupt enable and priority
        csr(2'b01, 12'h304, 32'hFFFF_FFFF);
        csr(2'b10, 12'h300, 32'h0000_0008);
        rd_expect(12'h304, 32'h0000_0880, "mie_warl");
        irq_timer = 1'b1;
        #1 check("irq_timer_req", {31'd0, irq_req}, 32'd1);
        check("irq_timer_cause", irq_cause, 32'h8000_0007);
        tick();
        irq_ext = 1'b1;
        #1 check("irq_ext_cause", irq_cause, 32'h8000_000B);
        tick();

        // Vectored trap target and trap entry
        csr(2'b01, 12'h305, 32'h0000_0101);
        exc_cause = 32'h8000_0007;
        #1 check("tvec_vectored", trap_vector, 32'h0000_011C);
        tick();
        exc_cause = 32'h0000_0002;
        #1 check("tvec_exception", trap_vector, 32'h0000_0100);
        exc_valid = 1'b1; exc_pc = 32'h0000_4000; exc_tval = 32'h0000_0009;
        tick();
        exc_valid = 1'b0;
        rd_expect(12'h300, 32'h0000_1880, "mstatus_after_trap");
        check("mepc_after_trap", mepc_out, 32'h0000_4000);

        // Trap beats mret beats CSR write; then mret alone
        csr(2'b10, 12'h300, 32'h0000_0008);
        exc_valid = 1'b1; exc_pc = 32'h0000_2000; exc_cause = 32'h0000_0003; mret = 1'b1;
        csr(2'b01, 12'h341, 32'h0000_1234);
        exc_valid = 1'b0; mret = 1'b0;
        check("mepc_priority", mepc_out, 32'h0000_2000);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd_expect(12'h300, 32'h0000_1888, "mstatus_after_mret");

        // Counter carry and write-over-increment
        do_reset();
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd_expect(12'hB00, 32'h0000_0000, "mcycle_lo_carry");
        rd_expect(12'hB80, 32'h0000_0001, "mcycle_hi_carry");
        csr(2'b01, 12'hB00, 32'h0000_0055);
        rd_expect(12'hB00, 32'h0000_0055, "mcycle_lo_written");
        csr(2'b01, 12'hB80, 32'h0000_0007);
        rd_expect(12'hB80, 32'h0000_0007, "mcycle_hi_written");
        instret = 1'b1;
        csr(2'b01, 12'hB02, 32'h0000_0AAA);
        instret = 1'b0;
        rd_expect(12'hB02, 32'h0000_0AAA, "minstret_written");

        // Read-only mip
        irq_timer = 1'b1; irq_ext = 1'b0;
        bus.csr_en = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = 12'h344; bus.csr_wdata = 32'd5;
        #1 check("mip_write_illegal", {31'd0, bus.csr_illegal}, 32'd1);
        tick();
        rd_expect(12'h344, 32'h0000_0080, "mip_unchanged");
        bus.csr_en = 1'b1; bus.csr_op = 2'b10; bus.csr_addr = 12'h344; bus.csr_wdata = 32'd0;
        #1 check("mip_rs0_legal", {31'd0, bus.csr_illegal}, 32'd0);
        tick();
        bus.csr_en = 1'b0;

        // Reset in the middle of a committing trap
        csr(2'b01, 12'h340, 32'h1357_9BDF);
        exc_valid = 1'b1; exc_pc = 32'h0000_ABC0; exc_cause = 32'h0000_0005;
        bus.csr_en = 1'b1; bus.csr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 32'hFFFF;
        #2;
        do_reset();
        rd_expect(12'h340, 32'd0, "mscratch_after_reset");
        rd_expect(12'h342, 32'd0, "mcause_after_reset");
        rd_expect(12'hB00, 32'd2, "mcycle_after_reset");

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            bus.csr_en    = ($urandom_range(0, 9) < 7);
            bus.csr_op    = 2'($urandom_range(0, 3));
            bus.csr_addr  = alist[$urandom_range(0, 14)];
            bus.csr_wdata = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            exc_valid     = ($urandom_range(0, 19) == 0);
            mret          = ($urandom_range(0, 19) == 0);
            instret       = 1'($urandom_range(0, 1));
            irq_timer     = 1'($urandom_range(0, 1));
            irq_ext       = 1'($urandom_range(0, 1));
            exc_cause     = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 15))};
            exc_pc        = $urandom;
            exc_tval      = $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
